// File: rtl/cpu_io_device.sv
// cpu_io_device: device side of the CPU in/out port protocol.
// An input FIFO (host push, CPU pop) feeds in_data; an output FIFO
// (CPU push, host pop) captures CPU writes. Sticky flags record a CPU
// read from an empty input FIFO and a CPU write into a full output FIFO.
module cpu_io_device #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned IN_DEPTH   = 8,
    parameter int unsigned OUT_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_signal,
    output logic [DATA_WIDTH-1:0]        in_data,
    input  logic                         out_signal,
    input  logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         host_in_valid,
    input  logic [DATA_WIDTH-1:0]        host_in_data,
    output logic                         host_in_ready,
    output logic                         host_out_valid,
    output logic [DATA_WIDTH-1:0]        host_out_data,
    input  logic                         host_out_ready,
    output logic [$clog2(IN_DEPTH):0]    in_count,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    input  logic                         err_clear,
    output logic                         in_underflow,
    output logic                         out_overflow,
    output logic                         error
);

    localparam int unsigned IN_AW  = $clog2(IN_DEPTH);
    localparam int unsigned IN_CW  = IN_AW + 1;
    localparam int unsigned OUT_AW = $clog2(OUT_DEPTH);
    localparam int unsigned OUT_CW = OUT_AW + 1;

    localparam logic [IN_CW-1:0]  IN_FULL  = IN_CW'(IN_DEPTH);
    localparam logic [OUT_CW-1:0] OUT_FULL = OUT_CW'(OUT_DEPTH);

    logic [DATA_WIDTH-1:0] in_mem  [IN_DEPTH];
    logic [DATA_WIDTH-1:0] out_mem [OUT_DEPTH];

    logic [IN_AW-1:0]  in_wr;
    logic [IN_AW-1:0]  in_rd;
    logic [OUT_AW-1:0] out_wr;
    logic [OUT_AW-1:0] out_rd;

    logic in_push;
    logic in_pop;
    logic in_under_set;
    logic out_push;
    logic out_pop;
    logic out_over_set;

    // Handshake decode; all decisions use the occupancy at the start of the cycle.
    assign host_in_ready  = (in_count != IN_FULL);
    assign in_push        = host_in_valid & host_in_ready;
    assign in_pop         = in_signal & (in_count != '0);
    assign in_under_set   = in_signal & (in_count == '0);

    assign host_out_valid = (out_count != '0);
    assign out_pop        = host_out_valid & host_out_ready;
    assign out_push       = out_signal & (out_count != OUT_FULL);
    assign out_over_set   = out_signal & (out_count == OUT_FULL);

    // Zero-latency heads; forced to zero when empty so stale storage never leaks.
    assign in_data        = (in_count  != '0) ? in_mem[in_rd]   : '0;
    assign host_out_data  = (out_count != '0) ? out_mem[out_rd] : '0;
    assign error          = in_underflow | out_overflow;

    // FIFO storage writes (contents are not reset).
    always_ff @(posedge clk) begin
        if (reset && in_push) begin
            in_mem[in_wr] <= host_in_data;
        end
        if (reset && out_push) begin
            out_mem[out_wr] <= out_data;
        end
    end

    // Input FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_wr    <= '0;
            in_rd    <= '0;
            in_count <= '0;
        end else begin
            if (in_push) begin
                in_wr <= in_wr + IN_AW'(1);
            end
            if (in_pop) begin
                in_rd <= in_rd + IN_AW'(1);
            end
            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + IN_CW'(1);
                2'b01:   in_count <= in_count - IN_CW'(1);
                default: in_count <= in_count;
            endcase
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
        end else begin
            if (out_push) begin
                out_wr <= out_wr + OUT_AW'(1);
            end
            if (out_pop) begin
                out_rd <= out_rd + OUT_AW'(1);
            end
            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + OUT_CW'(1);
                2'b01:   out_count <= out_count - OUT_CW'(1);
                default: out_count <= out_count;
            endcase
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_underflow <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            in_underflow <= in_under_set | (in_underflow & ~err_clear);
            out_overflow <= out_over_set | (out_overflow & ~err_clear);
        end
    end

endmodule

// File: tb/tb_cpu_io_device.sv
// Directed testbench for cpu_io_device.
module tb_cpu_io_device;

    localparam int unsigned DW = 64;

    logic          clk;
    logic          reset;
    logic          in_signal;
    logic [DW-1:0] in_data;
    logic          out_signal;
    logic [DW-1:0] out_data;
    logic          host_in_valid;
    logic [DW-1:0] host_in_data;
    logic          host_in_ready;
    logic          host_out_valid;
    logic [DW-1:0] host_out_data;
    logic          host_out_ready;
    logic [3:0]    in_count;
    logic [3:0]    out_count;
    logic          err_clear;
    logic          in_underflow;
    logic          out_overflow;
    logic          error;

    int checks = 0;
    int errors = 0;

    cpu_io_device #(.DATA_WIDTH(DW), .IN_DEPTH(8), .OUT_DEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .in_signal(in_signal), .in_data(in_data),
        .out_signal(out_signal), .out_data(out_data),
        .host_in_valid(host_in_valid), .host_in_data(host_in_data),
        .host_in_ready(host_in_ready),
        .host_out_valid(host_out_valid), .host_out_data(host_out_data),
        .host_out_ready(host_out_ready),
        .in_count(in_count), .out_count(out_count),
        .err_clear(err_clear), .in_underflow(in_underflow),
        .out_overflow(out_overflow), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; inputs are driven and outputs sampled 1ns after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_signal      = 1'b0;
        out_signal     = 1'b0;
        out_data       = '0;
        host_in_valid  = 1'b0;
        host_in_data   = '0;
        host_out_ready = 1'b0;
        err_clear      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_signal      = 1'($urandom);
            out_signal     = 1'($urandom);
            out_data       = {$urandom, $urandom};
            host_in_valid  = 1'($urandom);
            host_in_data   = {$urandom, $urandom};
            host_out_ready = 1'($urandom);
            err_clear      = 1'($urandom);
            cyc();
        end
        idle_inputs();
        #1;
        checks++; if (in_count !== 4'd0) begin errors++; $display("FAIL reset_in_count got %0d exp 0", in_count); end
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count got %0d exp 0", out_count); end
        checks++; if (host_in_ready !== 1'b1) begin errors++; $display("FAIL reset_host_in_ready got %b exp 1", host_in_ready); end
        checks++; if (host_out_valid !== 1'b0) begin errors++; $display("FAIL reset_host_out_valid got %b exp 0", host_out_valid); end
        checks++; if (error !== 1'b0 || in_underflow !== 1'b0 || out_overflow !== 1'b0) begin errors++; $display("FAIL reset_flags got %b%b%b exp 000", error, in_underflow, out_overflow); end
        checks++; if (in_data !== 64'h0) begin errors++; $display("FAIL reset_in_data got %h exp 0", in_data); end
        checks++; if (host_out_data !== 64'h0) begin errors++; $display("FAIL reset_host_out_data got %h exp 0", host_out_data); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_in_order();
        logic [DW-1:0] vals [3];
        vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
        for (int i = 0; i < 3; i++) begin
            host_in_valid = 1'b1; host_in_data = vals[i];
            cyc();
        end
        host_in_valid = 1'b0;
        checks++; if (in_count !== 4'd3) begin errors++; $display("FAIL order_count_full got %0d exp 3", in_count); end
        for (int i = 0; i < 3; i++) begin
            in_signal = 1'b1;
            #1;
            checks++; if (in_data !== vals[i]) begin errors++; $display("FAIL order_in_data[%0d] got %h exp %h", i, in_data, vals[i]); end
            cyc();
        end
        in_signal = 1'b0;
        checks++; if (in_count !== 4'd0) begin errors++; $display("FAIL order_count_empty got %0d exp 0", in_count); end
        checks++; if (in_underflow !== 1'b0) begin errors++; $display("FAIL order_underflow got %b exp 0", in_underflow); end
    endtask

    task automatic test_in_full_wrap();
        logic [DW-1:0] exp_q [8];
        for (int i = 0; i < 8; i++) begin
            host_in_valid = 1'b1; host_in_data = 64'h100 + 64'(i);
            cyc();
        end
        host_in_valid = 1'b0;
        checks++; if (in_count !== 4'd8) begin errors++; $display("FAIL full_count got %0d exp 8", in_count); end
        checks++; if (host_in_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", host_in_ready); end
        host_in_valid = 1'b1; host_in_data = 64'h1FF;
        cyc();
        host_in_valid = 1'b0;
        checks++; if (in_count !== 4'd8) begin errors++; $display("FAIL full_ninth_count got %0d exp 8", in_count); end
        for (int i = 0; i < 3; i++) begin
            in_signal = 1'b1;
            #1;
            checks++; if (in_data !== 64'h100 + 64'(i)) begin errors++; $display("FAIL wrap_pop3[%0d] got %h exp %h", i, in_data, 64'h100 + 64'(i)); end
            cyc();
        end
        in_signal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            host_in_valid = 1'b1; host_in_data = 64'h200 + 64'(i);
            cyc();
        end
        host_in_valid = 1'b0;
        checks++; if (in_count !== 4'd8) begin errors++; $display("FAIL wrap_refill_count got %0d exp 8", in_count); end
        for (int i = 0; i < 5; i++) exp_q[i] = 64'h103 + 64'(i);
        for (int i = 0; i < 3; i++) exp_q[5+i] = 64'h200 + 64'(i);
        for (int i = 0; i < 8; i++) begin
            in_signal = 1'b1;
            #1;
            checks++; if (in_data !== exp_q[i]) begin errors++; $display("FAIL wrap_drain[%0d] got %h exp %h", i, in_data, exp_q[i]); end
            cyc();
        end
        in_signal = 1'b0;
        checks++; if (in_count !== 4'd0 || in_underflow !== 1'b0) begin errors++; $display("FAIL wrap_end got count %0d uf %b exp 0 0", in_count, in_underflow); end
    endtask

    task automatic test_underflow();
        in_signal = 1'b1; host_in_valid = 1'b1; host_in_data = 64'hAB;
        #1;
        checks++; if (in_data !== 64'h0) begin errors++; $display("FAIL uf_in_data got %h exp 0", in_data); end
        cyc();
        in_signal = 1'b0; host_in_valid = 1'b0;
        checks++; if (in_underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %b exp 1", in_underflow); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL uf_error got %b exp 1", error); end
        checks++; if (in_count !== 4'd1) begin errors++; $display("FAIL uf_count got %0d exp 1", in_count); end
        in_signal = 1'b1;
        #1;
        checks++; if (in_data !== 64'hAB) begin errors++; $display("FAIL uf_next_data got %h exp ab", in_data); end
        cyc();
        in_signal = 1'b0; err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        checks++; if (in_underflow !== 1'b0 || in_count !== 4'd0) begin errors++; $display("FAIL uf_cleanup got uf %b count %0d exp 0 0", in_underflow, in_count); end
    endtask

    task automatic test_out_overflow();
        host_out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            out_signal = 1'b1; out_data = 64'(i);
            cyc();
        end
        out_signal = 1'b0;
        checks++; if (out_count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", out_count); end
        checks++; if (out_overflow !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b err %b exp 1 1", out_overflow, error); end
        host_out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            checks++; if (host_out_valid !== 1'b1 || host_out_data !== 64'(i)) begin errors++; $display("FAIL ovf_drain[%0d] got v %b d %h exp 1 %h", i, host_out_valid, host_out_data, 64'(i)); end
            cyc();
        end
        host_out_ready = 1'b0;
        checks++; if (host_out_valid !== 1'b0 || out_count !== 4'd0 || host_out_data !== 64'h0) begin errors++; $display("FAIL ovf_empty got v %b count %0d d %h exp 0 0 0", host_out_valid, out_count, host_out_data); end
    endtask

    task automatic test_flag_clear();
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
        checks++; if (out_overflow !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL clr_alone got ovf %b err %b exp 0 0", out_overflow, error); end
        err_clear = 1'b1; in_signal = 1'b1;
        cyc();
        err_clear = 1'b0; in_signal = 1'b0;
        checks++; if (in_underflow !== 1'b1 || error !== 1'b1) begin errors++; $display("FAIL clr_priority got uf %b err %b exp 1 1", in_underflow, error); end
        err_clear = 1'b1;
        cyc();
        err_clear = 1'b0;
    endtask

    task automatic test_back_to_back();
        host_in_valid = 1'b1; host_in_data = 64'hA1;
        cyc();
        host_in_data = 64'hB2; in_signal = 1'b1;
        #1;
        checks++; if (in_data !== 64'hA1) begin errors++; $display("FAIL b2b_in_head got %h exp a1", in_data); end
        cyc();
        host_in_valid = 1'b0;
        checks++; if (in_count !== 4'd1) begin errors++; $display("FAIL b2b_in_count got %0d exp 1", in_count); end
        checks++; if (in_data !== 64'hB2) begin errors++; $display("FAIL b2b_in_next got %h exp b2", in_data); end
        cyc();
        in_signal = 1'b0;
        out_signal = 1'b1; out_data = 64'h5;
        cyc();
        out_data = 64'h6; host_out_ready = 1'b1;
        #1;
        checks++; if (host_out_data !== 64'h5) begin errors++; $display("FAIL b2b_out_head got %h exp 5", host_out_data); end
        cyc();
        out_signal = 1'b0; host_out_ready = 1'b0;
        checks++; if (out_count !== 4'd1 || host_out_data !== 64'h6) begin errors++; $display("FAIL b2b_out_next got count %0d d %h exp 1 6", out_count, host_out_data); end
        checks++; if (error !== 1'b0 || in_count !== 4'd0) begin errors++; $display("FAIL b2b_clean got err %b in_count %0d exp 0 0", error, in_count); end
    endtask

    task automatic test_reset_mid();
        host_in_valid = 1'b1; host_in_data = 64'h77;
        out_signal = 1'b1; out_data = 64'h88;
        cyc();
        idle_inputs();
        reset = 1'b0; in_signal = 1'b1; out_signal = 1'b1;
        cyc();
        reset = 1'b1; in_signal = 1'b0; out_signal = 1'b0;
        checks++; if (in_count !== 4'd0 || out_count !== 4'd0) begin errors++; $display("FAIL rmid_counts got %0d %0d exp 0 0", in_count, out_count); end
        checks++; if (in_data !== 64'h0 || host_out_data !== 64'h0 || error !== 1'b0) begin errors++; $display("FAIL rmid_outputs got %h %h err %b exp 0 0 0", in_data, host_out_data, error); end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        #1;
        test_reset();
        test_in_order();
        test_in_full_wrap();
        test_underflow();
        test_out_overflow();
        test_flag_clear();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
